neuron_mac_scheduler: RTL and testbench

- Time-multiplexed sequencer for one dense layer: a single signed MAC computes all NEURON_NUM neurons one after another instead of NEURON_NUM parallel dot-product units.
- Reads inputs, weights and biases from external synchronous RAMs and applies optional ReLU.
- Streams each neuron result out with a valid/ready handshake.
- Sits between the layer parameter memories and the next layer's input buffer.

---
 rtl/neuron_mac_scheduler_if.sv | 27 ++
 rtl/neuron_mac_scheduler.sv | 133 +++++++++++++
 tb/tb_neuron_mac_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_scheduler_if.sv
// neuron_mac_scheduler_if: parameter-RAM read ports and result stream of the MAC scheduler
interface neuron_mac_scheduler_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int NEURON_WIDTH = 824,
    parameter int NEURON_NUM   = 10,
    parameter int B_BITS       = 32,
    parameter int OUT_WIDTH    = DATA_WIDTH + 8
);
    localparam int IW = NEURON_WIDTH > 1 ? $clog2(NEURON_WIDTH) : 1;
    localparam int WW = NEURON_NUM * NEURON_WIDTH > 1 ? $clog2(NEURON_NUM * NEURON_WIDTH) : 1;
    localparam int BW = NEURON_NUM > 1 ? $clog2(NEURON_NUM) : 1;
    logic                        in_rd_en, w_rd_en, b_rd_en, out_valid, out_ready;
    logic [IW-1:0]               in_addr;
    logic [WW-1:0]               w_addr;
    logic [BW-1:0]               b_addr, out_idx;
    logic signed [DATA_WIDTH-1:0] in_data, w_data;
    logic signed [B_BITS-1:0]    b_data;
    logic signed [OUT_WIDTH-1:0] out_data;
    modport master (
        output in_rd_en, in_addr, w_rd_en, w_addr, b_rd_en, b_addr, out_valid, out_idx, out_data,
        input  in_data, w_data, b_data, out_ready
    );
    modport slave (
        input  in_rd_en, in_addr, w_rd_en, w_addr, b_rd_en, b_addr, out_valid, out_idx, out_data,
        output in_data, w_data, b_data, out_ready
    );
endinterface

// File: rtl/neuron_mac_scheduler.sv
// neuron_mac_scheduler: single signed MAC sequencing all neurons of a dense layer; define NN_SCHED_ABORT_EN for an abort input
module neuron_mac_scheduler #(
    parameter int DATA_WIDTH   = 32,
    parameter int NEURON_WIDTH = 824,
    parameter int NEURON_NUM   = 10,
    parameter int B_BITS       = 32,
    parameter int ACC_WIDTH    = 2 * DATA_WIDTH + $clog2(NEURON_WIDTH) + 1,
    parameter int OUT_WIDTH    = DATA_WIDTH + 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic relu_en_i,
`ifdef NN_SCHED_ABORT_EN
    input  logic abort_i,
`endif
    output logic busy_o,
    output logic done_o,
    neuron_mac_scheduler_if.master bus
);
    localparam int IW = NEURON_WIDTH > 1 ? $clog2(NEURON_WIDTH) : 1;
    localparam int WW = NEURON_NUM * NEURON_WIDTH > 1 ? $clog2(NEURON_NUM * NEURON_WIDTH) : 1;
    localparam int BW = NEURON_NUM > 1 ? $clog2(NEURON_NUM) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [IW-1:0] K_LAST = IW'(NEURON_WIDTH - 1);
    localparam logic [BW-1:0] N_LAST = BW'(NEURON_NUM - 1);
    localparam logic signed [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] AMAX = {{(ACC_WIDTH-OUT_WIDTH){1'b0}}, OMAX};
    localparam logic signed [ACC_WIDTH-1:0] AMIN = {{(ACC_WIDTH-OUT_WIDTH){1'b1}}, OMIN};

    typedef enum logic [2:0] {IDLE, BIAS, MAC, FLUSH, OUT} state_t;

    state_t                       state_q, state_d;
    logic [BW-1:0]                n_q, n_d, out_idx_q, out_idx_d;
    logic [IW-1:0]                k_q, k_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_sum, relu_v;
    logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d, sat_v;
    logic                         relu_q, relu_d, done_q, done_d, abort;
    logic [PW-1:0]                prod;

`ifdef NN_SCHED_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // Sign-extended operands keep the low 2*DATA_WIDTH product bits identical to a signed multiply
    assign prod    = {{DATA_WIDTH{bus.in_data[DATA_WIDTH-1]}}, bus.in_data} *
                     {{DATA_WIDTH{bus.w_data[DATA_WIDTH-1]}}, bus.w_data};
    assign acc_sum = acc_q + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    assign relu_v  = (relu_q && acc_sum[ACC_WIDTH-1]) ? '0 : acc_sum;
    assign sat_v   = relu_v > AMAX ? OMAX : relu_v < AMIN ? OMIN : relu_v[OUT_WIDTH-1:0];

    // Next-state and datapath updates; the final product is folded into the result during FLUSH
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        acc_d      = acc_q;
        relu_d     = relu_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: if (start_i && !done_q) begin
                state_d = BIAS;
                relu_d  = relu_en_i;
                n_d     = '0;
            end
            BIAS: begin
                state_d = MAC;
                k_d     = '0;
            end
            MAC: begin
                acc_d   = k_q == '0 ? {{(ACC_WIDTH-B_BITS){bus.b_data[B_BITS-1]}}, bus.b_data} : acc_sum;
                k_d     = k_q + 1'b1;
                state_d = k_q == K_LAST ? FLUSH : MAC;
            end
            FLUSH: begin
                acc_d      = acc_sum;
                out_data_d = sat_v;
                out_idx_d  = n_q;
                state_d    = OUT;
            end
            OUT: if (bus.out_ready) begin
                state_d = n_q == N_LAST ? IDLE : BIAS;
                done_d  = n_q == N_LAST;
                n_d     = n_q == N_LAST ? n_q : n_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            relu_q     <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            relu_q     <= relu_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            done_q     <= done_d;
        end
    end

    assign busy_o        = state_q != IDLE;
    assign done_o        = done_q;
    assign bus.b_rd_en   = state_q == BIAS;
    assign bus.in_rd_en  = state_q == MAC;
    assign bus.w_rd_en   = state_q == MAC;
    assign bus.b_addr    = bus.b_rd_en ? n_q : '0;
    assign bus.in_addr   = bus.in_rd_en ? k_q : '0;
    assign bus.w_addr    = bus.w_rd_en ? WW'(n_q) * WW'(NEURON_WIDTH) + WW'(k_q) : '0;
    assign bus.out_valid = state_q == OUT;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_neuron_mac_scheduler.sv
// tb_neuron_mac_scheduler: scoreboard bench for the time-multiplexed MAC scheduler
module tb_neuron_mac_scheduler;
    localparam int DW = 32, NW = 4, NN = 2, BB = 32, OW = DW + 8;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu_en = 1'b0, busy, done;
`ifdef NN_SCHED_ABORT_EN
    logic abort = 1'b0;
`endif
    int checks = 0, errors = 0;
    logic signed [DW-1:0] in_mem [NW];
    logic signed [DW-1:0] w_mem  [NW*NN];
    logic signed [BB-1:0] b_mem  [NN];
    typedef struct { int idx; logic signed [OW-1:0] data; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    neuron_mac_scheduler_if #(.DATA_WIDTH(DW), .NEURON_WIDTH(NW), .NEURON_NUM(NN),
                              .B_BITS(BB), .OUT_WIDTH(OW)) bus ();

    neuron_mac_scheduler #(.DATA_WIDTH(DW), .NEURON_WIDTH(NW), .NEURON_NUM(NN),
                           .B_BITS(BB), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .relu_en_i(relu_en),
`ifdef NN_SCHED_ABORT_EN
        .abort_i(abort),
`endif
        .busy_o(busy), .done_o(done), .bus(bus)
    );

    // Synchronous RAM models with one-cycle read latency
    always @(posedge clk) begin
        if (bus.in_rd_en) bus.in_data <= in_mem[bus.in_addr];
        if (bus.w_rd_en) bus.w_data <= w_mem[bus.w_addr];
        if (bus.b_rd_en) bus.b_data <= b_mem[bus.b_addr];
    end

    function automatic logic signed [OW-1:0] model(input int n, input logic relu);
        logic signed [127:0] a, mx, mn;
        mx = (128'sd1 <<< (OW - 1)) - 128'sd1;
        mn = -mx - 128'sd1;
        a = b_mem[n];
        for (int k = 0; k < NW; k++) a = a + in_mem[k] * w_mem[n*NW+k];
        if (relu && a < 0) a = 0;
        if (a > mx) a = mx;
        if (a < mn) a = mn;
        return a[OW-1:0];
    endfunction

    task automatic load_basic();
        for (int k = 0; k < NW; k++) begin
            in_mem[k] = k + 1;
            w_mem[k] = 1;
            w_mem[NW+k] = -1;
        end
        b_mem[0] = 5;
        b_mem[1] = 0;
    endtask

    task automatic load_saturation();
        for (int k = 0; k < NW; k++) begin
            in_mem[k] = 32'sh7FFF_FFFF;
            w_mem[k] = 32'sh7FFF_FFFF;
            w_mem[NW+k] = 32'sh8000_0001;
        end
        b_mem[0] = 0;
        b_mem[1] = 0;
    endtask

    task automatic run_pass(input logic relu, input int stall, input int mid_start);
        int cyc, first_v, st, hold_i;
        logic signed [OW-1:0] hold_d;
        bit got_done;
        exp_t e;
        first_v = -1;
        st = stall;
        got_done = 0;
        hold_i = 0;
        hold_d = '0;
        for (int n = 0; n < NN; n++) sb.push_back('{n, model(n, relu)});
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        relu_en = ~relu;
        cyc = 1;
        while (!got_done && cyc < 200) begin
            start = (cyc == mid_start);
            if (bus.out_valid && first_v < 0) begin
                first_v = cyc;
                hold_d = bus.out_data;
                hold_i = int'(bus.out_idx);
            end
            if (first_v >= 0 && st > 0) begin
                bus.out_ready = 1'b0;
                st--;
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== hold_d || int'(bus.out_idx) != hold_i) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d: valid=%b data=%0d idx=%0d, required valid=1 data=%0d idx=%0d",
                             cyc, bus.out_valid, bus.out_data, bus.out_idx, hold_d, hold_i);
                end
                checks++;
                if ({bus.in_rd_en, bus.w_rd_en, bus.b_rd_en} !== 3'b000) begin
                    errors++;
                    $display("FAIL stall_reads cyc=%0d: strobes=%b, required 000", cyc,
                             {bus.in_rd_en, bus.w_rd_en, bus.b_rd_en});
                end
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: idx=%0d data=%0d, required no output", bus.out_idx, bus.out_data);
                end else begin
                    e = sb.pop_front();
                    if (int'(bus.out_idx) != e.idx) begin
                        errors++;
                        $display("FAIL out_idx: got %0d, required %0d", bus.out_idx, e.idx);
                    end
                    checks++;
                    if (bus.out_data !== e.data) begin
                        errors++;
                        $display("FAIL out_data idx=%0d: got %0d, required %0d", e.idx, bus.out_data, e.data);
                    end
                end
            end
            if (done) begin
                got_done = 1;
                checks++;
                if (cyc != NN * (NW + 3) + 1 + stall) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d, required %0d", cyc, NN * (NW + 3) + 1 + stall);
                end
                checks++;
                if (busy !== 1'b0 || sb.size() != 0) begin
                    errors++;
                    $display("FAIL done_state: busy=%b pending=%0d, required busy=0 pending=0", busy, sb.size());
                end
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL pass_timeout: no done within %0d cycles, required done", cyc);
            sb.delete();
        end
        checks++;
        if (first_v != NW + 3) begin
            errors++;
            $display("FAIL first_valid_cycle: got %0d, required %0d", first_v, NW + 3);
        end
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b valid=%b, required 0 0 0", busy, done, bus.out_valid);
        end
        checks++;
        if ({bus.in_rd_en, bus.w_rd_en, bus.b_rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes: got %b, required 000", {bus.in_rd_en, bus.w_rd_en, bus.b_rd_en});
        end
        checks++;
        if (bus.out_data !== '0 || bus.out_idx !== '0) begin
            errors++;
            $display("FAIL reset_out: data=%0d idx=%0d, required 0 0", bus.out_data, bus.out_idx);
        end
    endtask

    task automatic test_basic();
        load_basic();
        run_pass(1'b0, 0, 0);
    endtask

    task automatic test_relu();
        run_pass(1'b1, 0, 0);
    endtask

    task automatic test_backpressure();
        run_pass(1'b0, 5, 0);
    endtask

    task automatic test_back_to_back_mid_start();
        run_pass(1'b0, 0, 3);
    endtask

    task automatic test_saturation();
        load_saturation();
        run_pass(1'b0, 0, 0);
    endtask

    task automatic test_reset_mid_pass();
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_rd_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_mac: in_rd_en=%b busy=%b, required 1 1", bus.in_rd_en, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, bus.out_valid, bus.in_rd_en, bus.w_rd_en, bus.b_rd_en} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_ctrl: busy/done/valid/strobes=%b, required 000000",
                     {busy, done, bus.out_valid, bus.in_rd_en, bus.w_rd_en, bus.b_rd_en});
        end
        checks++;
        if (bus.out_data !== '0 || bus.in_addr !== '0 || bus.w_addr !== '0) begin
            errors++;
            $display("FAIL async_reset_data: out_data=%0d in_addr=%0d w_addr=%0d, required 0 0 0",
                     bus.out_data, bus.in_addr, bus.w_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        load_basic();
        run_pass(1'b1, 0, 0);
    endtask

`ifdef NN_SCHED_ABORT_EN
    task automatic test_abort();
        int c;
        bit saw_done;
        c = 0;
        saw_done = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!bus.out_valid && c < 50) begin
            c++;
            @(negedge clk);
        end
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL abort_wait_valid: out_valid=0 after %0d cycles, required 1", c);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, bus.out_valid, bus.in_rd_en, bus.w_rd_en, bus.b_rd_en} !== 5'b0) begin
            errors++;
            $display("FAIL abort_idle: busy/valid/strobes=%b, required 00000",
                     {busy, bus.out_valid, bus.in_rd_en, bus.w_rd_en, bus.b_rd_en});
        end
        for (int i = 0; i < 10; i++) begin
            if (done) saw_done = 1;
            @(negedge clk);
        end
        checks++;
        if (saw_done || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done_seen=%b busy=%b, required 0 0", saw_done, busy);
        end
        run_pass(1'b0, 0, 0);
    endtask
`endif

    initial begin
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_relu();
        test_backpressure();
        test_back_to_back_mid_start();
        test_saturation();
        test_reset_mid_pass();
`ifdef NN_SCHED_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
